// File: rtl/mult_arb_pkg.sv
// Shared types, widths and the round-robin pick function for the shared multiplier arbiter.
package mult_arb_pkg;

    localparam int unsigned OP_W     = 16;
    localparam int unsigned PROD_W   = 32;
    localparam int unsigned MAX_REQ  = 16;
    localparam int unsigned ID_MAX_W = 4;

    typedef struct packed {
        logic [OP_W-1:0]     a;
        logic [OP_W-1:0]     b;
        logic [ID_MAX_W-1:0] id;
    } s1_entry_t;

    // One-hot grant to the first valid requester at or after ptr, wrapping at nreq.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [ID_MAX_W-1:0] ptr,
        input int unsigned         nreq
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int unsigned        idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned off = 0; off < MAX_REQ; off++) begin
            idx = (32'(ptr) + off) % nreq;
            if (off < nreq && !found && valid[idx[ID_MAX_W-1:0]]) begin
                grant[idx[ID_MAX_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/mult_arbiter_16_if.sv
// Requester/consumer bundle of the shared multiplier; master drives requests, slave is the arbiter.
interface mult_arbiter_16_if #(
    parameter int unsigned NREQ = 4
) ();
    localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]                    req_valid;
    logic [NREQ-1:0]                    req_ready;
    logic [NREQ*mult_arb_pkg::OP_W-1:0] req_a;
    logic [NREQ*mult_arb_pkg::OP_W-1:0] req_b;
    logic                               rsp_valid;
    logic                               rsp_ready;
    logic [ID_W-1:0]                    rsp_id;
    logic [mult_arb_pkg::PROD_W-1:0]    rsp_product;
    logic                               busy;
    logic [15:0]                        op_count;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product, busy, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product, busy, op_count
    );
endinterface

// File: rtl/dadda_unsigned_multiplier_16.sv
// Combinational 16x16 unsigned multiplier: Dadda column reduction to two rows, then one adder.
module dadda_unsigned_multiplier_16
    import mult_arb_pkg::*;
(
    input  logic [OP_W-1:0]   i_a,
    input  logic [OP_W-1:0]   i_b,
    output logic [PROD_W-1:0] o_product
);
    localparam int unsigned COLS   = PROD_W;
    localparam int unsigned ROWS   = OP_W + 1;
    localparam int unsigned STAGES = 6;

    function automatic int unsigned dadda_limit(input int unsigned stage);
        case (stage)
            0:       return 13;
            1:       return 9;
            2:       return 6;
            3:       return 4;
            4:       return 3;
            default: return 2;
        endcase
    endfunction

    logic [COLS-1:0] w_row0;
    logic [COLS-1:0] w_row1;

    always_comb begin
        logic        cur [COLS][ROWS];
        logic        nxt [COLS][ROWS];
        int unsigned h   [COLS];
        int unsigned nh  [COLS];
        int unsigned lim;
        int unsigned p;
        int unsigned rem;
        logic        x;
        logic        y;
        logic        z;
        lim = 0;
        p   = 0;
        rem = 0;
        x   = 1'b0;
        y   = 1'b0;
        z   = 1'b0;
        for (int unsigned k = 0; k < COLS; k++) begin
            h[k]  = 0;
            nh[k] = 0;
            for (int unsigned r = 0; r < ROWS; r++) begin
                cur[k][r] = 1'b0;
                nxt[k][r] = 1'b0;
            end
        end
        for (int unsigned i = 0; i < OP_W; i++) begin
            for (int unsigned j = 0; j < OP_W; j++) begin
                cur[i+j][h[i+j]] = i_a[i] & i_b[j];
                h[i+j]++;
            end
        end
        // Each stage squeezes every column (own bits plus carries from below) down to lim.
        for (int unsigned s = 0; s < STAGES; s++) begin
            lim = dadda_limit(s);
            for (int unsigned k = 0; k < COLS; k++) begin
                nh[k] = 0;
                for (int unsigned r = 0; r < ROWS; r++) begin
                    nxt[k][r] = 1'b0;
                end
            end
            for (int unsigned k = 0; k < COLS; k++) begin
                p   = 0;
                rem = h[k];
                for (int unsigned it = 0; it < OP_W; it++) begin
                    if (rem + nh[k] > lim && rem >= 2) begin
                        x = cur[k][p];
                        y = cur[k][p+1];
                        if (rem + nh[k] == lim + 1 || rem == 2) begin
                            nxt[k][nh[k]] = x ^ y;
                            if (k + 1 < COLS) begin
                                nxt[k+1][nh[k+1]] = x & y;
                                nh[k+1]++;
                            end
                            nh[k]++;
                            p   += 2;
                            rem -= 2;
                        end else begin
                            z = cur[k][p+2];
                            nxt[k][nh[k]] = x ^ y ^ z;
                            if (k + 1 < COLS) begin
                                nxt[k+1][nh[k+1]] = (x & y) | (x & z) | (y & z);
                                nh[k+1]++;
                            end
                            nh[k]++;
                            p   += 3;
                            rem -= 3;
                        end
                    end
                end
                for (int unsigned r = 0; r < ROWS; r++) begin
                    if (r < rem) begin
                        nxt[k][nh[k]] = cur[k][p+r];
                        nh[k]++;
                    end
                end
            end
            for (int unsigned k = 0; k < COLS; k++) begin
                h[k] = nh[k];
                for (int unsigned r = 0; r < ROWS; r++) begin
                    cur[k][r] = nxt[k][r];
                end
            end
        end
        for (int unsigned k = 0; k < COLS; k++) begin
            w_row0[k] = cur[k][0];
            w_row1[k] = cur[k][1];
        end
    end

    assign o_product = w_row0 + w_row1;

endmodule

// File: rtl/mult_arbiter_16.sv
// Round-robin arbiter feeding one shared 16x16 multiplier through a two-stage valid/ready pipe.
module mult_arbiter_16
    import mult_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    mult_arbiter_16_if.slave io_bus
);
    localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    s1_entry_t           r_s1;
    logic                r_s1_valid;
    logic [ID_W-1:0]     r_ptr;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [PROD_W-1:0]   r_rsp_product;
    logic [15:0]         r_op_count;

    logic                w_adv1;
    logic                w_adv2;
    logic                w_accept;
    logic [MAX_REQ-1:0]  w_pick;
    logic [NREQ-1:0]     w_grant;
    logic [ID_MAX_W-1:0] w_gidx;
    logic [ID_W-1:0]     w_ptr_next;
    logic [OP_W-1:0]     w_a;
    logic [OP_W-1:0]     w_b;
    logic [PROD_W-1:0]   w_prod;

    assign w_adv2   = !r_rsp_valid || io_bus.rsp_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign w_pick   = rr_pick(MAX_REQ'(io_bus.req_valid), ID_MAX_W'(r_ptr), NREQ);
    assign w_grant  = NREQ'(w_pick);
    // Reset gating keeps req_ready low while rst_n is held, even if requesters are valid.
    assign w_accept = w_adv1 && i_rst_n && (|w_pick);

    always_comb begin
        w_gidx = '0;
        w_a    = '0;
        w_b    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gidx = ID_MAX_W'(i);
                w_a    = io_bus.req_a[i*OP_W +: OP_W];
                w_b    = io_bus.req_b[i*OP_W +: OP_W];
            end
        end
    end

    assign w_ptr_next = (32'(w_gidx) == NREQ - 1) ? '0 : ID_W'(32'(w_gidx) + 32'd1);

    dadda_unsigned_multiplier_16 u_mult (
        .i_a       (r_s1.a),
        .i_b       (r_s1.b),
        .o_product (w_prod)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1          <= '0;
            r_s1_valid    <= 1'b0;
            r_ptr         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
            r_op_count    <= '0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1  <= '{a: w_a, b: w_b, id: w_gidx};
                    r_ptr <= w_ptr_next;
                end
            end
            if (w_adv2) begin
                r_rsp_valid   <= r_s1_valid;
                r_rsp_product <= w_prod;
                r_rsp_id      <= ID_W'(r_s1.id);
            end
            if (r_rsp_valid && io_bus.rsp_ready) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    assign io_bus.req_ready   = w_grant & {NREQ{w_adv1 && i_rst_n}};
    assign io_bus.rsp_valid   = r_rsp_valid;
    assign io_bus.rsp_id      = r_rsp_id;
    assign io_bus.rsp_product = r_rsp_product;
    assign io_bus.busy        = r_s1_valid || r_rsp_valid;
    assign io_bus.op_count    = r_op_count;

endmodule

// File: doc/mult_arbiter_16.md
# mult_arbiter_16

Shares one combinational 16x16 unsigned Dadda multiplier among NREQ requesters. Round-robin arbitration, a registered operand stage and a registered result stage give a 2-cycle, fully pipelined path with valid/ready handshakes on both sides. Each result is returned tagged with the requester index. The block sits between client datapaths and the multiplier so that one multiplier instance serves several units.

## Interface
- NREQ, 4: number of requesters, 1..16.
- ID_W, $clog2(NREQ) (minimum 1): width of the requester tag.
- clk  in  1  rising-edge clock, single domain.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  bit i: requester i presents an operand pair.
- req_ready  out  NREQ  bit i: requester i's pair is accepted this cycle.
- req_a  in  NREQ*16  operand A of requester i at bits [16i+15:16i].
- req_b  in  NREQ*16  operand B of requester i, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  requester index of the result.
- rsp_product  out  32  unsigned A*B.
- busy  out  1  at least one pipeline stage holds a valid entry.
- op_count  out  16  number of completed response handshakes, wraps modulo 2^16.

## Operation
- Stage S1 holds s1_valid, s1_a, s1_b and s1_id. The multiplier computes combinationally from S1. Stage S2 holds rsp_valid, rsp_product and rsp_id.
- Stall rules:
  - adv2 = !rsp_valid | rsp_ready.
  - adv1 = !s1_valid | adv2.
- Arbitration:
  - Recomputed every cycle.
  - Grant goes to the first i with req_valid[i] = 1, scanning from ptr upward with wrap.
  - req_ready = onehot(grant) & {NREQ{adv1}}. At most one bit is high, and it is high only when that requester is valid.
- Accept: on req_valid[i] & req_ready[i], S1 loads (A_i, B_i, i) and ptr becomes (i+1) mod NREQ. If nothing is accepted, ptr holds.
- When adv1 = 1 and nothing is accepted, s1_valid becomes 0.
- When adv2 = 1, S2 loads the multiplier output and s1_id, and rsp_valid becomes s1_valid. While a stage stalls, its registers hold unchanged.
- Requester rule: a requester must keep valid and operands stable until it sees ready. The arbiter may move its grant to another valid requester while stalled. This is legal because no handshake has completed.
- op_count increments on rsp_valid & rsp_ready.
- busy = s1_valid | rsp_valid.
- Arithmetic: the product is full 32-bit unsigned, with no truncation and no rounding.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_id 0, rsp_product 0, busy 0, op_count 0, ptr 0, s1_valid 0, s1_a/s1_b/s1_id 0.
- Latency: a request accepted at edge k gives rsp_valid = 1 after edge k+1 (visible in cycle k+1). It stays high until rsp_ready is sampled high.
- Throughput: 1 result per cycle while rsp_ready = 1.
- Full pipeline, rsp_ready = 0: both stages hold and all req_ready are 0. Raising rsp_ready for one cycle frees one slot, and one new request is accepted in that same cycle.
- Simultaneous response handshake and new acceptance in one cycle: both happen and nothing is lost.
- rsp_ready is combinationally reflected into req_ready. There is no combinational path from req_* to rsp_*.
- Reset asserted mid-operation: in-flight entries are discarded, and all outputs take their reset values at the next edge.
- NREQ = 1: ptr is constant 0 and rsp_id is 0.

## Structure
- Package mult_arb_pkg contains:
  - OP_W = 16 and PROD_W = 32.
  - typedef s1_entry_t {a, b, id}.
  - A function rr_pick(valid, ptr) that returns the one-hot grant.
- One sub-module: the existing combinational dadda_unsigned_multiplier_16, instantiated once between S1 and S2.
- The arbiter, pipeline registers and counter live in the top module only.

## Test plan
- Single request: req_valid[2] = 1 with A = 0xFFFF, B = 0xFFFF and rsp_ready = 1. Expect req_ready[2] in the same cycle, then 1 cycle later rsp_valid = 1, rsp_product = 0xFFFE0001, rsp_id = 2, and op_count = 1 after the handshake.
- Fairness: all 4 requesters valid continuously, each with A = i+1 and B = 0x0100. Expect grants 0,1,2,3,0,1 on consecutive cycles, and products 0x100, 0x200, 0x300, 0x400 in that order.
- Backpressure: 4 back-to-back requests with rsp_ready = 0. Expect 2 acceptances, then all req_ready = 0 and busy = 1. Then pulse rsp_ready for 1 cycle. Expect exactly one result retired and one new request accepted.
- Zero and edge operands: (0, 0x1234) -> 0; (1, 0xFFFF) -> 0x0000FFFF; (0x8000, 0x8000) -> 0x40000000.
- Reset mid-flight: rst_n = 0 for 1 cycle while both stages are valid. Expect rsp_valid = 0, busy = 0, op_count = 0 and ptr = 0 on the following cycle, and no stale response afterwards.
- Randomised soak: 10,000 handshakes with random valid and rsp_ready. The scoreboard checks product and id per requester, order per requester, and op_count mod 2^16.
